// File: rtl/eth_tx_arb_pkg.sv
// Shared definitions for the Ethernet TX frame arbiter: FSM encoding, abort filler byte
// and the AXI-stream beat payload carried from the selected port to the MAC.
package eth_tx_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [7:0] ABORT_BYTE = 8'h00;

  typedef struct packed {
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;
  } axis_beat_t;

endpackage

// File: rtl/rr_prio_sel.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping,
// found with a doubled request vector so one priority search covers the wrap.
module rr_prio_sel #(
  parameter int unsigned PORTS = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam int unsigned DW = 2 * PORTS;

  logic [DW-1:0] dbl;
  logic [DW-1:0] thermo;
  logic [DW-1:0] masked;
  logic [DW-1:0] lowest;

  always_comb begin
    dbl    = {req_i, req_i};
    thermo = {DW{1'b1}} << ptr_i;
    masked = dbl & thermo;
    // Isolate the lowest set bit; the upper copy supplies the wrapped candidates.
    lowest = masked & (~masked + DW'(1));
    gnt_o  = lowest[PORTS-1:0] | lowest[DW-1:PORTS];
    idx_o  = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (gnt_o[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/eth_tx_frame_arb.sv
// Frame-granular round-robin arbiter feeding the 1G MAC TX AXI-stream; a granted port
// owns the datapath until its tlast, and a starvation watchdog closes stalled frames as errored.
module eth_tx_frame_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int unsigned PORTS   = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [8*PORTS-1:0]         s_axis_tdata,
  input  logic [PORTS-1:0]           s_axis_tvalid,
  output logic [PORTS-1:0]           s_axis_tready,
  input  logic [PORTS-1:0]           s_axis_tlast,
  input  logic [PORTS-1:0]           s_axis_tuser,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic [PORTS-1:0]           grant,
  output logic                       abort,
  output logic [$clog2(PORTS)-1:0]   abort_port
);

  localparam int unsigned IDX_W = $clog2(PORTS);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             abort_q, abort_d;
  logic [IDX_W-1:0] abort_port_q, abort_port_d;

  logic [PORTS-1:0] sel_gnt;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic [IDX_W-1:0] next_ptr;
  axis_beat_t       own;
  axis_beat_t       mout;

  rr_prio_sel #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_sel (
    .req_i (s_axis_tvalid),
    .ptr_i (rr_ptr_q),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  // Beat presented by the current owner.
  always_comb begin
    own = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        own.tdata  = s_axis_tdata[8*i +: 8];
        own.tvalid = s_axis_tvalid[i];
        own.tlast  = s_axis_tlast[i];
        own.tuser  = s_axis_tuser[i];
      end
    end
  end

  assign next_ptr = (gidx_q == IDX_W'(PORTS - 1)) ? '0 : gidx_q + IDX_W'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    stall_d       = stall_q;
    abort_d       = 1'b0;
    abort_port_d  = abort_port_q;
    mout          = '0;
    s_axis_tready = '0;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          grant_d = sel_gnt;
          gidx_d  = sel_idx;
          stall_d = '0;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        mout          = own;
        s_axis_tready = grant_q & {PORTS{m_axis_tready}};
        if (own.tvalid) begin
          stall_d = '0;
          if (m_axis_tready && own.tlast) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
          end
        end else if ((TIMEOUT != 0) && (stall_q == STALL_LAST)) begin
          stall_d = '0;
          state_d = ST_ABORT;
        end else begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      ST_ABORT: begin
        mout.tdata  = ABORT_BYTE;
        mout.tvalid = 1'b1;
        mout.tlast  = 1'b1;
        mout.tuser  = 1'b1;
        if (m_axis_tready) begin
          abort_d      = 1'b1;
          abort_port_d = gidx_q;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Swallow the rest of the dead frame so the port is realigned on a frame boundary.
        s_axis_tready = grant_q;
        if (own.tvalid && own.tlast) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      rr_ptr_q     <= '0;
      stall_q      <= '0;
      abort_q      <= 1'b0;
      abort_port_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      rr_ptr_q     <= rr_ptr_d;
      stall_q      <= stall_d;
      abort_q      <= abort_d;
      abort_port_q <= abort_port_d;
    end
  end

  assign m_axis_tdata  = mout.tdata;
  assign m_axis_tvalid = mout.tvalid;
  assign m_axis_tlast  = mout.tlast;
  assign m_axis_tuser  = mout.tuser;
  assign grant         = grant_q;
  assign abort         = abort_q;
  assign abort_port    = abort_port_q;

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Bench for eth_tx_frame_arb: per-port frame sources, a random MAC sink and a frame-level
// reference model predicting the output beat stream and abort events.
module tb_eth_tx_frame_arb;

  localparam int unsigned P  = 3;
  localparam int unsigned TO = 4;

  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         user;
    int         gap;
  } beat_t;

  typedef struct {
    int         port;
    logic [7:0] data;
    bit         last;
    bit         user;
    bit         is_abort;
  } obeat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [8*P-1:0] s_axis_tdata;
  logic [P-1:0]   s_axis_tvalid;
  logic [P-1:0]   s_axis_tready;
  logic [P-1:0]   s_axis_tlast;
  logic [P-1:0]   s_axis_tuser;
  logic [7:0]     m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic           m_axis_tuser;
  logic [P-1:0]   grant;
  logic           abort;
  logic [1:0]     abort_port;

  always #5 clk = ~clk;

  eth_tx_frame_arb #(.PORTS(P), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .grant         (grant),
    .abort         (abort),
    .abort_port    (abort_port)
  );

  beat_t  src_q [P][$];
  int     cur_gap [P];
  obeat_t exp_q [$];
  int     checks = 0;
  int     errors = 0;
  int     mdl_ptr = 0;
  int     mac_pct = 100;
  int     mac_block = 0;
  bit     exp_abort = 0;
  int     exp_abort_port = 0;
  bit     chk_idle = 0;
  bit     chk_idle2 = 0;
  int     gaps_tbl [7] = '{0, 1, 2, 3, 4, 5, 7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit any_src();
    for (int p = 0; p < P; p++) if (src_q[p].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit work_left();
    return any_src() || (exp_q.size() > 0) || exp_abort || chk_idle || chk_idle2;
  endfunction

  task automatic add_frame(input int p, input int len, input int gap_at, input int gap_len);
    beat_t b;
    if (src_q[p].size() == 0) cur_gap[p] = 0;
    for (int j = 0; j < len; j++) begin
      b.data = 8'($urandom);
      b.last = (j == len - 1);
      b.user = 1'($urandom_range(0, 1));
      b.gap  = (j == gap_at) ? gap_len : 0;
      src_q[p].push_back(b);
    end
  endtask

  // Frame-level prediction: round-robin over ports holding frames, a gap of TO or more
  // starved cycles truncates the frame into one errored 00 beat, and the rest is discarded.
  task automatic build_expected();
    beat_t mq [P][$];
    beat_t b;
    int    found;
    int    q;
    int    j;
    bit    ab;
    for (int p = 0; p < P; p++) mq[p] = src_q[p];
    forever begin
      found = -1;
      for (int k = 0; k < P; k++) begin
        q = (mdl_ptr + k) % P;
        if (found < 0 && mq[q].size() > 0) found = q;
      end
      if (found < 0) break;
      ab = 1'b0;
      j  = 0;
      do begin
        b = mq[found].pop_front();
        if (!ab && j > 0 && b.gap >= TO) begin
          ab = 1'b1;
          exp_q.push_back('{found, 8'h00, 1'b1, 1'b1, 1'b1});
        end
        if (!ab) exp_q.push_back('{found, b.data, b.last, b.user, 1'b0});
        j++;
      end while (!b.last);
      mdl_ptr = (found + 1) % P;
    end
  endtask

  task automatic run_cycle();
    obeat_t     e;
    logic [P-1:0] eg;
    @(negedge clk);
    for (int p = 0; p < P; p++) begin
      s_axis_tvalid[p] = (src_q[p].size() > 0) && (cur_gap[p] == 0);
      if (src_q[p].size() > 0) begin
        s_axis_tdata[8*p +: 8] = src_q[p][0].data;
        s_axis_tlast[p]        = src_q[p][0].last;
        s_axis_tuser[p]        = src_q[p][0].user;
      end else begin
        s_axis_tdata[8*p +: 8] = 8'($urandom);
        s_axis_tlast[p]        = 1'b0;
        s_axis_tuser[p]        = 1'b0;
      end
    end
    if (mac_block > 0) begin
      m_axis_tready = 1'b0;
      mac_block--;
    end else begin
      m_axis_tready = ($urandom_range(1, 100) <= mac_pct);
    end
    #1;
    if (exp_abort) begin
      chk("abort_pulse", 32'(abort), 32'd1);
      chk("abort_port", 32'(abort_port), 32'(exp_abort_port));
      exp_abort = 1'b0;
    end else begin
      chk("abort_quiet", 32'(abort), 32'd0);
    end
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("tready_owner", 32'(s_axis_tready & ~grant), 32'd0);
    if (chk_idle2) begin
      chk("b2b_regrant", 32'(|grant), 32'd1);
      chk_idle2 = 1'b0;
    end
    if (chk_idle) begin
      chk("idle_grant", 32'(grant), 32'd0);
      chk("idle_valid", 32'(m_axis_tvalid), 32'd0);
      chk_idle  = 1'b0;
      chk_idle2 = any_src();
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        eg = '0;
        eg[e.port] = 1'b1;
        chk("beat_data", 32'(m_axis_tdata), 32'(e.data));
        chk("beat_last", 32'(m_axis_tlast), 32'(e.last));
        chk("beat_user", 32'(m_axis_tuser), 32'(e.user));
        chk("beat_owner", 32'(grant), 32'(eg));
        if (e.is_abort) begin
          exp_abort      = 1'b1;
          exp_abort_port = e.port;
        end else if (e.last) begin
          chk_idle = 1'b1;
        end
      end
    end
    for (int p = 0; p < P; p++) begin
      if (s_axis_tvalid[p] && s_axis_tready[p]) begin
        void'(src_q[p].pop_front());
        cur_gap[p] = (src_q[p].size() > 0) ? src_q[p][0].gap : 0;
      end else if (cur_gap[p] > 0) begin
        cur_gap[p]--;
      end
    end
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (work_left() && n < budget) begin
      run_cycle();
      n++;
    end
    chk(tag, 32'(work_left()), 32'd0);
  endtask

  initial begin
    int nf;
    int len;
    int ga;
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    for (int p = 0; p < P; p++) cur_gap[p] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    repeat (3) run_cycle();
    chk("quiet_grant", 32'(grant), 32'd0);

    // Single 60-byte frame on port 0, one cycle arbitration latency
    add_frame(0, 60, -1, 0);
    build_expected();
    run_cycle();
    chk("lat_idle", 32'(grant), 32'd0);
    run_cycle();
    chk("lat_grant", 32'(grant), 32'd1);
    run_until_done("frame60_done", 200);

    // Reset in the middle of a frame
    add_frame(0, 30, -1, 0);
    build_expected();
    repeat (6) run_cycle();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_tready", 32'(s_axis_tready), 32'd0);
    chk("midrst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_mdata", 32'(m_axis_tdata), 32'd0);
    chk("midrst_mlast", 32'(m_axis_tlast), 32'd0);
    for (int p = 0; p < P; p++) src_q[p].delete();
    exp_q.delete();
    exp_abort = 1'b0;
    chk_idle  = 1'b0;
    chk_idle2 = 1'b0;
    mdl_ptr   = 0;
    @(negedge clk);
    s_axis_tvalid = '0;
    rst_n = 1'b1;

    // Two ports with three frames each, including single-beat frames
    add_frame(0, 7, -1, 0);  add_frame(1, 1, -1, 0);
    add_frame(0, 1, -1, 0);  add_frame(1, 12, -1, 0);
    add_frame(0, 5, -1, 0);  add_frame(1, 3, -1, 0);
    build_expected();
    run_until_done("alt_done", 300);

    // Watchdog abort on port 1 after byte 10, then a clean follow-up frame
    add_frame(1, 16, 10, 4);
    add_frame(1, 5, -1, 0);
    build_expected();
    run_until_done("abort_done", 300);

    // Source returns on the last starved cycle before the limit: no abort
    add_frame(0, 12, 5, 3);
    build_expected();
    run_until_done("gap3_done", 300);

    // Long MAC backpressure with the source valid: no watchdog
    add_frame(2, 20, -1, 0);
    build_expected();
    repeat (5) run_cycle();
    mac_block = 500;
    run_until_done("bp_done", 1000);

    // Randomised traffic: frame counts, lengths, gaps, tuser and MAC readiness
    mac_pct = 70;
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < P; p++) begin
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(1, 12);
          ga  = (len > 1) ? $urandom_range(1, len - 1) : -1;
          add_frame(p, len, ga, gaps_tbl[$urandom_range(0, 6)]);
        end
      end
      build_expected();
      run_until_done("rand_done", 3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
